add_sub_result_buffer: RTL and testbench

- Receiving end of the add_sub_unit output interface.
- Captures each completed result (rs_id, destination GPR, 32-bit result, cond_exception_t flags) into a small in-order FIFO.
- Presents the oldest entry to the common data bus (CDB) arbiter with a valid/ready handshake.
- The add_sub_unit cannot be stalled, so the block drives an early-stall signal back to the issue side and flags any overflow.

---
 rtl/ppc_types.sv | 14 +
 rtl/add_sub_result_buffer.sv | 170 +++++++++++++++++
 tb/tb_add_sub_result_buffer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ppc_types.sv
// Shared PowerPC execution-side types.
// cond_exception_t carries the CR0/XER side effects produced by an integer op.
package ppc_types;

    typedef struct packed {
        logic       cr0_update;  // CR0 field must be written
        logic [0:3] cr0;         // LT GT EQ SO
        logic       xer_update;  // XER[SO,OV,CA] must be written
        logic       so;
        logic       ov;
        logic       ca;
    } cond_exception_t;

endpackage

// File: rtl/add_sub_result_buffer.sv
// add_sub_result_buffer: in-order result FIFO between the add_sub_unit and the
// CDB arbiter. The add_sub_unit cannot stall, so issue_stall is raised early
// enough to absorb the results still in flight, and any dropped result sets a
// sticky overflow_err.
//
// Optional feature macro: ADD_SUB_RESULT_BYPASS_EN
//   When defined, an empty buffer forwards the incoming result straight to the
//   cdb_* outputs in the same cycle. If the CDB grants it, the FIFO is skipped;
//   otherwise the result is also pushed and stays at the head.
module add_sub_result_buffer
    import ppc_types::*;
#(
    parameter int unsigned RS_ID_WIDTH = 5,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SLACK       = 2
) (
    input  logic                     clk,
    input  logic                     rst,

    // add_sub_unit result interface
    input  logic                     output_valid,
    input  logic [RS_ID_WIDTH-1:0]   rs_id_out,
    input  logic [0:4]               result_reg_addr_out,
    input  logic [0:31]              result,
    input  cond_exception_t          cr0_xer,

    // CDB arbiter interface
    output logic                     cdb_valid,
    input  logic                     cdb_ready,
    output logic [RS_ID_WIDTH-1:0]   cdb_rs_id,
    output logic [0:4]               cdb_reg_addr,
    output logic [0:31]              cdb_result,
    output cond_exception_t          cdb_cr0_xer,

    // Status
    output logic                     issue_stall,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    // Stall while the remaining free slots can only just hold the in-flight results.
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - SLACK);

    typedef struct packed {
        logic [RS_ID_WIDTH-1:0] rs_id;
        logic [0:4]             reg_addr;
        logic [0:31]            value;
        cond_exception_t        flags;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    entry_t             in_entry;
    entry_t             head_entry;
    logic               fifo_valid;
    logic               full;
    logic               pop;
    logic               push;
    logic               bypass_take;

    assign in_entry = '{
        rs_id:    rs_id_out,
        reg_addr: result_reg_addr_out,
        value:    result,
        flags:    cr0_xer
    };

    assign fifo_valid = (count_q != '0);
    assign full       = (count_q == FULL_CNT);
    // Only a stored head can be popped; a bypassed result never enters the FIFO.
    assign pop        = fifo_valid && cdb_ready;

`ifdef ADD_SUB_RESULT_BYPASS_EN
    assign bypass_take = !fifo_valid && output_valid && cdb_ready;
`else
    assign bypass_take = 1'b0;
`endif

    // A full FIFO still accepts a result when the head leaves in the same cycle.
    assign push = output_valid && !bypass_take && (!full || pop);

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        // Pointer width equals log2(DEPTH), so the increment wraps by itself.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (output_valid && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // Control state register; reset discards every entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    // Head presentation; data is forced to zero while nothing is valid.
    always_comb begin
        cdb_valid  = fifo_valid;
        head_entry = fifo_valid ? mem_q[rd_ptr_q] : '0;
`ifdef ADD_SUB_RESULT_BYPASS_EN
        if (!fifo_valid && output_valid) begin
            cdb_valid  = 1'b1;
            head_entry = in_entry;
        end
`endif
    end

    assign cdb_rs_id    = head_entry.rs_id;
    assign cdb_reg_addr = head_entry.reg_addr;
    assign cdb_result   = head_entry.value;
    assign cdb_cr0_xer  = head_entry.flags;

    assign issue_stall  = (count_q >= STALL_CNT);
    assign count        = count_q;
    assign overflow_err = overflow_q;

    // Occupancy can never exceed the storage.
    a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= FULL_CNT);

    // A held head must not change under backpressure.
    a_head_stable: assert property (@(posedge clk) disable iff (rst)
        (fifo_valid && !cdb_ready) |=> (head_entry == $past(head_entry)));

endmodule

// File: tb/tb_add_sub_result_buffer.sv
// Scoreboard bench for add_sub_result_buffer (default build, no bypass).
// Stimulus pushes expected entries into a queue; a negedge monitor pops and
// compares whenever the DUT completes a CDB transfer.
module tb_add_sub_result_buffer;
    import ppc_types::*;

    typedef struct packed {
        logic [4:0]  rs;
        logic [0:4]  ra;
        logic [0:31] res;
        logic [8:0]  fl;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            output_valid;
    logic [4:0]      rs_id_out;
    logic [0:4]      result_reg_addr_out;
    logic [0:31]     result;
    cond_exception_t cr0_xer;
    logic            cdb_valid;
    logic            cdb_ready;
    logic [4:0]      cdb_rs_id;
    logic [0:4]      cdb_reg_addr;
    logic [0:31]     cdb_result;
    cond_exception_t cdb_cr0_xer;
    logic            issue_stall;
    logic [2:0]      count;
    logic            overflow_err;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    add_sub_result_buffer #(
        .RS_ID_WIDTH (5),
        .DEPTH       (4),
        .SLACK       (2)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .output_valid        (output_valid),
        .rs_id_out           (rs_id_out),
        .result_reg_addr_out (result_reg_addr_out),
        .result              (result),
        .cr0_xer             (cr0_xer),
        .cdb_valid           (cdb_valid),
        .cdb_ready           (cdb_ready),
        .cdb_rs_id           (cdb_rs_id),
        .cdb_reg_addr        (cdb_reg_addr),
        .cdb_result          (cdb_result),
        .cdb_cr0_xer         (cdb_cr0_xer),
        .issue_stall         (issue_stall),
        .count               (count),
        .overflow_err        (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rs, input logic [0:4] ra, input logic [0:31] res,
                        input logic [8:0] fl, input bit accept);
        output_valid        = 1'b1;
        rs_id_out           = rs;
        result_reg_addr_out = ra;
        result              = res;
        cr0_xer             = cond_exception_t'(fl);
        if (accept) sb.push_back('{rs: rs, ra: ra, res: res, fl: fl});
        tick();
        output_valid = 1'b0;
    endtask

    // Monitor: a transfer completes on the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (!rst && cdb_valid && cdb_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", 64'(cdb_rs_id), 64'h0);
                chk("unexpected_pop_valid", 64'(cdb_valid), 64'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pop_rs_id",    64'(cdb_rs_id),    64'(e.rs));
                chk("pop_reg_addr", 64'(cdb_reg_addr), 64'(e.ra));
                chk("pop_result",   64'(cdb_result),   64'(e.res));
                chk("pop_flags",    64'(cdb_cr0_xer),  64'(e.fl));
            end
        end
    end

    initial begin
        rst                 = 1'b1;
        output_valid        = 1'b1;
        rs_id_out           = 5'd9;
        result_reg_addr_out = 5'd3;
        result              = 32'h5555_AAAA;
        cr0_xer             = cond_exception_t'(9'h1FF);
        cdb_ready           = 1'b0;

        // Reset while a result is offered
        tick();
        chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("rst_count",     64'(count),     64'h0);
        tick();
        rst          = 1'b0;
        output_valid = 1'b0;
        chk("idle_cdb_valid",   64'(cdb_valid),    64'h0);
        chk("idle_count",       64'(count),        64'h0);
        chk("idle_overflow",    64'(overflow_err), 64'h0);
        chk("idle_issue_stall", 64'(issue_stall),  64'h0);
        chk("idle_cdb_result",  64'(cdb_result),   64'h0);

        // Ready while empty must do nothing
        cdb_ready = 1'b1;
        tick();
        chk("empty_ready_count", 64'(count), 64'h0);

        // Single pass: visible one cycle after push, popped that cycle
        push(5'd0, 5'd31, 32'd276, 9'h0A5, 1'b1);
        chk("single_latency_valid", 64'(cdb_valid), 64'h1);
        chk("single_count",         64'(count),     64'h1);
        tick();
        chk("single_drained", 64'(count), 64'h0);

        // Burst under backpressure
        cdb_ready = 1'b0;
        push(5'd1, 5'd31, 32'd276,         9'h101, 1'b1);
        chk("burst_count1", 64'(count), 64'h1);
        chk("burst_stall1", 64'(issue_stall), 64'h0);
        push(5'd2, 5'd30, 32'd98,          9'h042, 1'b1);
        chk("burst_count2", 64'(count), 64'h2);
        chk("burst_stall2", 64'(issue_stall), 64'h1);
        push(5'd3, 5'd29, 32'h8000_0003,   9'h1C4, 1'b1);
        chk("burst_count3", 64'(count), 64'h3);
        push(5'd4, 5'd28, 32'h0000_0000,   9'h120, 1'b1);
        chk("burst_count4", 64'(count), 64'h4);
        chk("burst_stall4", 64'(issue_stall), 64'h1);
        chk("burst_head_result", 64'(cdb_result), 64'd276);
        tick();
        chk("held_head_rs_id", 64'(cdb_rs_id), 64'h1);

        // Full with simultaneous push and pop; new entry lands after wrap
        cdb_ready = 1'b1;
        push(5'd5, 5'd27, 32'h0000_1234, 9'h00F, 1'b1);
        cdb_ready = 1'b0;
        chk("full_pp_count",    64'(count),        64'h4);
        chk("full_pp_overflow", 64'(overflow_err), 64'h0);
        chk("full_pp_head",     64'(cdb_result),   64'd98);

        // Overflow: dropped, sticky, head untouched
        push(5'd7, 5'd26, 32'hDEAD_BEEF, 9'h1AA, 1'b0);
        chk("ovf_flag",  64'(overflow_err), 64'h1);
        chk("ovf_count", 64'(count),        64'h4);
        chk("ovf_head",  64'(cdb_rs_id),    64'h2);
        tick();
        chk("ovf_sticky", 64'(overflow_err), 64'h1);

        // Drain in push order
        cdb_ready = 1'b1;
        tick();
        chk("drain_count3", 64'(count), 64'h3);
        chk("drain_stall3", 64'(issue_stall), 64'h1);
        tick();
        tick();
        chk("drain_count1", 64'(count), 64'h1);
        chk("drain_stall1", 64'(issue_stall), 64'h0);
        tick();
        chk("drain_count0",    64'(count),        64'h0);
        chk("drain_ovf_still", 64'(overflow_err), 64'h1);

        // Reset in the middle of a burst
        cdb_ready = 1'b0;
        push(5'd8,  5'd1, 32'h0000_0011, 9'h001, 1'b1);
        push(5'd9,  5'd2, 32'h0000_0022, 9'h002, 1'b1);
        push(5'd10, 5'd3, 32'h0000_0033, 9'h003, 1'b1);
        chk("mid_count3", 64'(count), 64'h3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_valid",    64'(cdb_valid),    64'h0);
        chk("mid_rst_count",    64'(count),        64'h0);
        chk("mid_rst_overflow", 64'(overflow_err), 64'h0);
        chk("mid_rst_stall",    64'(issue_stall),  64'h0);
        tick();
        rst = 1'b0;

        // Pointers restart: the next result comes back out intact
        cdb_ready = 1'b1;
        push(5'd11, 5'd5, 32'hCAFE_F00D, 9'h155, 1'b1);
        chk("post_rst_rs_id",  64'(cdb_rs_id),  64'd11);
        chk("post_rst_result", 64'(cdb_result), 64'hCAFE_F00D);
        tick();
        chk("post_rst_count", 64'(count), 64'h0);

        tick();
        tick();
        chk("scoreboard_empty", 64'(sb.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
